// File: rtl/seq_alu.sv
// Sequential successor ALU: registered single-cycle ops plus iterative unsigned
// shift-add multiply and restoring divide, with latched condition flags.
module seq_alu #(
   parameter int WIDTH        = 8,
   parameter int ALU_OP_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clk_en,
   input  logic                    i_start,
   input  logic                    i_latch_flags,
   input  logic [ALU_OP_WIDTH-1:0] i_op,
   input  logic [WIDTH-1:0]        i_a,
   input  logic [WIDTH-1:0]        i_t,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [WIDTH-1:0]        o_data,
   output logic [WIDTH-1:0]        o_hi,
   output logic                    o_zero,
   output logic                    o_carry,
   output logic                    o_odd,
   output logic                    o_div0
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = ALU_OP_WIDTH'(0);
   localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = ALU_OP_WIDTH'(1);
   localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = ALU_OP_WIDTH'(2);
   localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = ALU_OP_WIDTH'(3);
   localparam logic [ALU_OP_WIDTH-1:0] OP_XOR  = ALU_OP_WIDTH'(4);
   localparam logic [ALU_OP_WIDTH-1:0] OP_SL   = ALU_OP_WIDTH'(5);
   localparam logic [ALU_OP_WIDTH-1:0] OP_SR   = ALU_OP_WIDTH'(6);
   localparam logic [ALU_OP_WIDTH-1:0] OP_ASR  = ALU_OP_WIDTH'(7);
   localparam logic [ALU_OP_WIDTH-1:0] OP_ROL  = ALU_OP_WIDTH'(8);
   localparam logic [ALU_OP_WIDTH-1:0] OP_ROR  = ALU_OP_WIDTH'(9);
   localparam logic [ALU_OP_WIDTH-1:0] OP_INV  = ALU_OP_WIDTH'(10);
   localparam logic [ALU_OP_WIDTH-1:0] OP_MULU = ALU_OP_WIDTH'(12);
   localparam logic [ALU_OP_WIDTH-1:0] OP_DIVU = ALU_OP_WIDTH'(13);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic              busy_q, done_q, zero_q, carry_q, odd_q, div0_q;
   logic              opDiv_q, latch_q;
   logic [WIDTH-1:0]  data_q, hi_q, opA_q, opT_q, workHi_q, workLo_q;

   logic [WIDTH:0]    addW_d, subW_d, mulSum_d, divShift_d;
   logic [WIDTH-1:0]  singleRes_d, singleHi_d, divDiff_d, nextHi_d, nextLo_d;
   logic              singleCarry_d, divFits_d, startLong_d;

   // Single-cycle result; CHK (and the unused codes 14/15) pass A through so
   // the flags reflect the operand. DIVU here only covers the T==0 shortcut.
   always_comb begin
      addW_d        = {1'b0, i_a} + {1'b0, i_t};
      subW_d        = {1'b0, i_a} - {1'b0, i_t};
      singleRes_d   = i_a;
      singleHi_d    = '0;
      singleCarry_d = 1'b0;
      case (i_op)
         OP_ADD:  begin singleRes_d = addW_d[WIDTH-1:0]; singleCarry_d = addW_d[WIDTH]; end
         OP_SUB:  begin singleRes_d = subW_d[WIDTH-1:0]; singleCarry_d = subW_d[WIDTH]; end
         OP_AND:  singleRes_d = i_a & i_t;
         OP_OR:   singleRes_d = i_a | i_t;
         OP_XOR:  singleRes_d = i_a ^ i_t;
         OP_SL:   begin singleRes_d = {i_a[WIDTH-2:0], 1'b0}; singleCarry_d = i_a[WIDTH-1]; end
         OP_SR:   begin singleRes_d = {1'b0, i_a[WIDTH-1:1]}; singleCarry_d = i_a[0]; end
         OP_ASR:  begin singleRes_d = {i_a[WIDTH-1], i_a[WIDTH-1:1]}; singleCarry_d = i_a[0]; end
         OP_ROL:  singleRes_d = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
         OP_ROR:  singleRes_d = {i_a[0], i_a[WIDTH-1:1]};
         OP_INV:  singleRes_d = ~i_a;
         OP_DIVU: begin singleRes_d = '1; singleHi_d = i_a; singleCarry_d = 1'b1; end
         default: singleRes_d = i_a;
      endcase
   end

   assign startLong_d = (i_op == OP_MULU) || ((i_op == OP_DIVU) && (i_t != '0));

   // One iteration step. Multiply shifts {hi,lo} right adding A when lo[0]
   // is set; divide shifts the remainder left and subtracts T when it fits.
   always_comb begin
      mulSum_d   = {1'b0, workHi_q} + (workLo_q[0] ? {1'b0, opA_q} : {(WIDTH+1){1'b0}});
      divShift_d = {workHi_q, workLo_q[WIDTH-1]};
      divFits_d  = divShift_d >= {1'b0, opT_q};
      divDiff_d  = divShift_d[WIDTH-1:0] - opT_q;
      if (opDiv_q) begin
         nextHi_d = divFits_d ? divDiff_d : divShift_d[WIDTH-1:0];
         nextLo_d = {workLo_q[WIDTH-2:0], divFits_d};
      end else begin
         nextHi_d = mulSum_d[WIDTH:1];
         nextLo_d = {mulSum_d[0], workLo_q[WIDTH-1:1]};
      end
   end

   // Control FSM with registered results and flags; clk_en freezes everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         data_q   <= '0;
         hi_q     <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         odd_q    <= 1'b0;
         div0_q   <= 1'b0;
         opDiv_q  <= 1'b0;
         latch_q  <= 1'b0;
         opA_q    <= '0;
         opT_q    <= '0;
         workHi_q <= '0;
         workLo_q <= '0;
      end else if (clk_en) begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_start && startLong_d) begin
                  opA_q    <= i_a;
                  opT_q    <= i_t;
                  opDiv_q  <= (i_op == OP_DIVU);
                  latch_q  <= i_latch_flags;
                  workHi_q <= '0;
                  workLo_q <= (i_op == OP_DIVU) ? i_a : i_t;
                  cnt_q    <= CW'(WIDTH);
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end else if (i_start) begin
                  data_q <= singleRes_d;
                  hi_q   <= singleHi_d;
                  done_q <= 1'b1;
                  if (i_latch_flags) begin
                     zero_q  <= (singleRes_d == '0);
                     carry_q <= singleCarry_d;
                     odd_q   <= singleRes_d[0];
                     if (i_op == OP_DIVU) div0_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               workHi_q <= nextHi_d;
               workLo_q <= nextLo_d;
               cnt_q    <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  data_q  <= nextLo_d;
                  hi_q    <= nextHi_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
                  if (latch_q) begin
                     zero_q  <= (nextLo_d == '0);
                     carry_q <= opDiv_q ? 1'b0 : (nextHi_d != '0);
                     odd_q   <= nextLo_d[0];
                     if (opDiv_q) div0_q <= 1'b0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_busy  = busy_q;
   assign o_done  = done_q;
   assign o_data  = data_q;
   assign o_hi    = hi_q;
   assign o_zero  = zero_q;
   assign o_carry = carry_q;
   assign o_odd   = odd_q;
   assign o_div0  = div0_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed scenarios followed by random ops
// compared against an arithmetic reference model.
module tb_seq_alu;

   localparam int W = 8;

   logic         clk, rst, clk_en, i_start, i_latch_flags;
   logic [3:0]   i_op;
   logic [W-1:0] i_a, i_t;
   logic         o_busy, o_done, o_zero, o_carry, o_odd, o_div0;
   logic [W-1:0] o_data, o_hi;

   int total = 0;
   int bad   = 0;
   int eZero = 0, eCarry = 0, eOdd = 0, eDiv0 = 0;

   seq_alu #(.WIDTH(W), .ALU_OP_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .i_start(i_start),
      .i_latch_flags(i_latch_flags), .i_op(i_op), .i_a(i_a), .i_t(i_t),
      .o_busy(o_busy), .o_done(o_done), .o_data(o_data), .o_hi(o_hi),
      .o_zero(o_zero), .o_carry(o_carry), .o_odd(o_odd), .o_div0(o_div0)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour from the op definitions, plain integer arithmetic.
   function automatic void model(input int op, input int a, input int t,
                                 output int d, output int h, output int c, output bit isLong);
      int s;
      d = a; h = 0; c = 0; isLong = 0;
      case (op)
         0:  begin s = a + t; d = s % 256; c = (s > 255) ? 1 : 0; end
         1:  begin d = (a - t) & 255; c = (a < t) ? 1 : 0; end
         2:  d = a & t;
         3:  d = a | t;
         4:  d = a ^ t;
         5:  begin d = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
         6:  begin d = a / 2; c = a % 2; end
         7:  begin d = (a >= 128) ? (a / 2 + 128) : a / 2; c = a % 2; end
         8:  d = (a * 2) % 256 + a / 128;
         9:  d = a / 2 + (a % 2) * 128;
         10: d = 255 - a;
         12: begin s = a * t; d = s % 256; h = s / 256; c = (h != 0) ? 1 : 0; isLong = 1; end
         13: begin
            if (t == 0) begin d = 255; h = a; c = 1; end
            else begin d = a / t; h = a % t; c = 0; isLong = 1; end
         end
         default: d = a;
      endcase
   endfunction

   task automatic checkFlags(input string tag);
      checkOutput({tag, "_zero"},  o_zero,  eZero);
      checkOutput({tag, "_carry"}, o_carry, eCarry);
      checkOutput({tag, "_odd"},   o_odd,   eOdd);
      checkOutput({tag, "_div0"},  o_div0,  eDiv0);
   endtask

   // Launch one op with clk_en high on the start edge, then follow it to done.
   task automatic applyStimulus(input string tag, input int op, input int a, input int t,
                                input bit latch, input bit toggleEn, input bit pulseMid);
      int d, h, c, en, cyc;
      bit isLong;
      model(op, a, t, d, h, c, isLong);
      clk_en = 1'b1; i_start = 1'b1; i_op = 4'(op);
      i_a = W'(a); i_t = W'(t); i_latch_flags = latch;
      tick();
      i_start = 1'b0;
      i_a = W'($urandom); i_t = W'($urandom); i_latch_flags = W'($urandom) != 0;
      if (isLong) begin
         checkOutput({tag, "_busy_start"}, o_busy, 1);
         checkOutput({tag, "_done_early"}, o_done, 0);
         en = 0; cyc = 0;
         while (o_done !== 1'b1 && cyc < 200) begin
            clk_en = toggleEn ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (pulseMid) begin
               i_start = ($urandom_range(0, 1) == 1);
               i_op = 4'($urandom_range(0, 15));
            end
            tick();
            if (clk_en) en++;
            cyc++;
         end
         i_start = 1'b0; clk_en = 1'b1;
         checkOutput({tag, "_en_cycles"}, en, W);
         checkOutput({tag, "_busy_end"}, o_busy, 0);
      end
      checkOutput({tag, "_done"}, o_done, 1);
      checkOutput({tag, "_data"}, o_data, d);
      checkOutput({tag, "_hi"},   o_hi,   h);
      if (latch) begin
         eZero = (d == 0) ? 1 : 0; eCarry = c; eOdd = d % 2;
         if (op == 13) eDiv0 = (t == 0) ? 1 : 0;
      end
      checkFlags(tag);
   endtask

   initial begin
      int sawDone;
      int op, a, t;
      rst = 1'b1; clk_en = 1'b1; i_start = 1'b0; i_latch_flags = 1'b0;
      i_op = '0; i_a = '0; i_t = '0;
      #12;
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_done", o_done, 0);
      checkOutput("rst_data", o_data, 0);
      checkOutput("rst_hi",   o_hi,   0);
      checkFlags("rst");
      #10 rst = 1'b0;
      tick();

      applyStimulus("add_ff_01", 0, 'hFF, 'h01, 1, 0, 0);
      applyStimulus("sub_03_05", 1, 'h03, 'h05, 0, 0, 0);
      applyStimulus("mul_ff_ff", 12, 'hFF, 'hFF, 1, 0, 1);
      applyStimulus("div_64_07", 13, 'h64, 'h07, 1, 0, 0);
      applyStimulus("div_64_00", 13, 'h64, 'h00, 1, 0, 0);
      applyStimulus("mul_toggle", 12, 'hB7, 'h5D, 1, 1, 0);

      // o_done holds while clk_en is low, then drops on the next enabled edge.
      clk_en = 1'b0;
      tick();
      checkOutput("hold_done", o_done, 1);
      clk_en = 1'b1;
      tick();
      checkOutput("drop_done", o_done, 0);

      // Asynchronous reset part-way through a divide.
      clk_en = 1'b1; i_start = 1'b1; i_op = 4'd13; i_a = 8'hC8; i_t = 8'h03; i_latch_flags = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (4) tick();
      checkOutput("pre_rst_busy", o_busy, 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_busy", o_busy, 0);
      checkOutput("midrst_done", o_done, 0);
      checkOutput("midrst_data", o_data, 0);
      checkOutput("midrst_hi",   o_hi,   0);
      eZero = 0; eCarry = 0; eOdd = 0; eDiv0 = 0;
      checkFlags("midrst");
      #3 rst = 1'b0;
      sawDone = 0;
      repeat (12) begin
         tick();
         if (o_done === 1'b1 || o_busy === 1'b1) sawDone = 1;
      end
      checkOutput("midrst_no_done", sawDone, 0);

      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 15);
         a  = $urandom_range(0, 255);
         t  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 255);
         applyStimulus($sformatf("rnd%0d_op%0d", i, op), op, a, t,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 1) == 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
